sha256_bench_ctrl: RTL and testbench

SHA256_BENCH_CTRL -- requirements
Module: sha256_bench_ctrl

---
 rtl/sha256_bench_ctrl.sv | 139 +++++++++++++
 tb/tb_sha256_bench_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_bench_ctrl.sv
// Drives a sha256 core back-to-back for a fixed time window and counts completed hashes.
// Each block is the template message with a big-endian nonce equal to the running hash count.
module sha256_bench_ctrl #(
    parameter int CLK_HZ           = 12000000,
    parameter int BENCHMARKSECONDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [511:0] input_buffer,
    input  logic         core_ready,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         core_start,
    output logic [511:0] core_block,
    output logic         busy,
    output logic         done,
    output logic [31:0]  hash_count,
    output logic [9:0]   seconds_elapsed,
    output logic [255:0] last_digest
);

    if (CLK_HZ < 1 || CLK_HZ > 100000000) begin : g_bad_clk_hz
        $fatal(1, "sha256_bench_ctrl: CLK_HZ out of range 1..100000000");
    end
    if (BENCHMARKSECONDS < 1 || BENCHMARKSECONDS > 600) begin : g_bad_seconds
        $fatal(1, "sha256_bench_ctrl: BENCHMARKSECONDS out of range 1..600");
    end

    localparam logic [26:0] PRE_MAX = 27'(CLK_HZ - 1);
    localparam logic [9:0]  SEC_MAX = 10'(BENCHMARKSECONDS);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StFinish} state_e;

    state_e         state_q;
    logic           core_start_q;
    logic [511:0]   core_block_q;
    logic           busy_q;
    logic           done_q;
    logic [31:0]    hash_count_q;
    logic [31:0]    hash_count_d;
    logic [9:0]     seconds_q;
    logic [26:0]    prescaler_q;
    logic [255:0]   last_digest_q;

    logic counting;
    logic wrap;
    logic window_end;
    logic expire;
    logic unused_nonce_bytes;

    // Bytes 60..63 of the template are replaced by the nonce.
    assign unused_nonce_bytes = ^input_buffer[31:0];

    always_comb begin
        counting     = (state_q == StIssue) || (state_q == StWait);
        wrap         = (prescaler_q == PRE_MAX);
        window_end   = counting && wrap && ((seconds_q + 10'd1) == SEC_MAX);
        expire       = window_end || (counting && abort);
        hash_count_d = (hash_count_q == 32'hFFFF_FFFF) ? hash_count_q : hash_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            core_start_q  <= 1'b0;
            core_block_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hash_count_q  <= '0;
            seconds_q     <= '0;
            prescaler_q   <= '0;
            last_digest_q <= '0;
        end else begin
            core_start_q <= 1'b0;
            // The window only runs while blocks are being issued or awaited.
            if (counting) begin
                prescaler_q <= wrap ? 27'd0 : prescaler_q + 27'd1;
                if (wrap) begin
                    seconds_q <= seconds_q + 10'd1;
                end
            end
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        hash_count_q  <= '0;
                        seconds_q     <= '0;
                        prescaler_q   <= '0;
                        last_digest_q <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    if (expire) begin
                        state_q <= StFinish;
                    end else if (core_ready) begin
                        core_start_q <= 1'b1;
                        core_block_q <= {input_buffer[511:32], hash_count_q};
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (core_done) begin
                        last_digest_q <= core_digest;
                        hash_count_q  <= hash_count_d;
                        state_q       <= expire ? StFinish : StIssue;
                    end else if (expire) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (core_done) begin
                        last_digest_q <= core_digest;
                        hash_count_q  <= hash_count_d;
                        state_q       <= StFinish;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_start      = core_start_q;
    assign core_block      = core_block_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign hash_count      = hash_count_q;
    assign seconds_elapsed = seconds_q;
    assign last_digest     = last_digest_q;

endmodule

// File: tb/tb_sha256_bench_ctrl.sv
// Directed bench for sha256_bench_ctrl: 10 Hz clock, 2 s window, fixed-latency core model.
// Expected issues are queued before each run and popped as core_start pulses appear.
module tb_sha256_bench_ctrl;

    localparam int LAT = 7;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [511:0] ibuf;
    logic         core_ready;
    logic         core_done;
    logic [255:0] core_digest;
    logic         core_start;
    logic [511:0] core_block;
    logic         busy;
    logic         done;
    logic [31:0]  hash_count;
    logic [9:0]   seconds_elapsed;
    logic [255:0] last_digest;

    int           total;
    int           bad;
    int           cyc;
    int           dly;
    bit           hold_on;
    logic [511:0] hold_blk;
    logic [31:0]  cur_nonce;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] nonce;
    } exp_t;
    exp_t q[$];

    sha256_bench_ctrl #(
        .CLK_HZ          (10),
        .BENCHMARKSECONDS(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .input_buffer   (ibuf),
        .core_ready     (core_ready),
        .core_done      (core_done),
        .core_digest    (core_digest),
        .core_start     (core_start),
        .core_block     (core_block),
        .busy           (busy),
        .done           (done),
        .hash_count     (hash_count),
        .seconds_elapsed(seconds_elapsed),
        .last_digest    (last_digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] dig(input logic [31:0] n);
        return {4{n ^ 32'hC3A5_96E1, ~n}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input int c, input logic [31:0] n);
        exp_t e;
        e.cyc   = 32'(c);
        e.nonce = n;
        q.push_back(e);
    endtask

    // One clock: core model and issue monitor run on the falling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (hold_on) chk("blk_hold", core_block, hold_blk);
        core_done = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                core_done   = 1'b1;
                core_digest = dig(cur_nonce);
                hold_on     = 1'b0;
            end
        end
        if (core_start === 1'b1) begin
            chk("issue_pending", 512'(q.size() != 0), 512'(1'b1));
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("issue_cyc", 512'(cyc), 512'(e.cyc));
                chk("issue_blk", core_block, {ibuf[511:32], e.nonce});
                hold_blk  = {ibuf[511:32], e.nonce};
                cur_nonce = e.nonce;
                hold_on   = 1'b1;
                dly       = LAT;
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_run();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
        chk("run_busy", 512'(busy), 512'(1'b1));
        chk("run_done_clr", 512'(done), 512'(1'b0));
        chk("run_cnt_clr", 512'(hash_count), 512'(0));
        chk("run_sec_clr", 512'(seconds_elapsed), 512'(0));
        chk("run_dig_clr", 512'(last_digest), 512'(0));
    endtask

    task automatic wait_done(input int exp_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", 512'(done), 512'(1'b1));
        chk("done_cyc", 512'(cyc), 512'(exp_cyc));
        chk("done_busy", 512'(busy), 512'(1'b0));
        chk("q_empty", 512'(q.size()), 512'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 512'(busy), 512'(1'b0));
        chk({tag, "_done"}, 512'(done), 512'(1'b0));
        chk({tag, "_cstart"}, 512'(core_start), 512'(1'b0));
        chk({tag, "_cnt"}, 512'(hash_count), 512'(0));
        chk({tag, "_sec"}, 512'(seconds_elapsed), 512'(0));
        chk({tag, "_dig"}, 512'(last_digest), 512'(0));
        chk({tag, "_blk"}, core_block, 512'(0));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        dly         = 0;
        hold_on     = 1'b0;
        hold_blk    = '0;
        cur_nonce   = '0;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        core_ready  = 1'b1;
        core_done   = 1'b0;
        core_digest = '0;
        ibuf        = {64{8'hAA}};
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk_zero("rst");

        // Basic run with nonce sequence 0,1,2 and an ignored start mid-run.
        expect_issue(2, 32'd0);
        expect_issue(11, 32'd1);
        expect_issue(20, 32'd2);
        start_run();
        run_to(12);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_cnt", 512'(hash_count), 512'(1));
        chk("ign_sec", 512'(seconds_elapsed), 512'(1));
        chk("ign_busy", 512'(busy), 512'(1'b1));
        wait_done(29);
        chk("basic_cnt", 512'(hash_count), 512'(3));
        chk("basic_sec", 512'(seconds_elapsed), 512'(2));
        chk("basic_dig", 512'(last_digest), 512'(dig(32'd2)));
        repeat (3) tick();
        chk("hold_done", 512'(done), 512'(1'b1));
        chk("hold_cnt", 512'(hash_count), 512'(3));

        // Backpressure: core_ready low for the first 5 ISSUE cycles.
        for (int i = 0; i < 16; i++) ibuf[i*32 +: 32] = $urandom;
        core_ready = 1'b0;
        expect_issue(7, 32'd0);
        expect_issue(16, 32'd1);
        start_run();
        while (cyc < 6) begin
            chk("bp_no_start", 512'(core_start), 512'(1'b0));
            tick();
        end
        core_ready = 1'b1;
        wait_done(25);
        chk("bp_cnt", 512'(hash_count), 512'(2));
        chk("bp_sec", 512'(seconds_elapsed), 512'(2));
        chk("bp_dig", 512'(last_digest), 512'(dig(32'd1)));

        // Coincidence: second core_done lands on the expiry cycle.
        for (int i = 0; i < 16; i++) ibuf[i*32 +: 32] = $urandom;
        expect_issue(2, 32'd0);
        expect_issue(13, 32'd1);
        start_run();
        run_to(10);
        core_ready = 1'b0;
        run_to(12);
        core_ready = 1'b1;
        wait_done(22);
        chk("co_cnt", 512'(hash_count), 512'(2));
        chk("co_sec", 512'(seconds_elapsed), 512'(2));
        chk("co_dig", 512'(last_digest), 512'(dig(32'd1)));

        // Abort while waiting: in-flight hash still counted.
        expect_issue(2, 32'd0);
        start_run();
        run_to(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(11);
        chk("ab_cnt", 512'(hash_count), 512'(1));
        chk("ab_sec", 512'(seconds_elapsed), 512'(0));
        chk("ab_dig", 512'(last_digest), 512'(dig(32'd0)));

        // Reset mid-WAIT; the stray core_done that follows must be ignored.
        expect_issue(2, 32'd0);
        start_run();
        run_to(4);
        hold_on = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("mid_rst");
        run_to(12);
        chk("stray_cnt", 512'(hash_count), 512'(0));
        chk("stray_dig", 512'(last_digest), 512'(0));
        chk("stray_busy", 512'(busy), 512'(1'b0));

        // start together with abort in IDLE is ignored.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        chk("sa_busy", 512'(busy), 512'(1'b0));
        chk("sa_cstart", 512'(core_start), 512'(1'b0));
        chk("sa_q_empty", 512'(q.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
